// File: rtl/bert_pkg.sv
// -----------------------------------------------------------------------------
// bert_pkg
// Shared definitions for the combined BERT datapath: pattern mode encodings,
// generator seeds, error-total saturation limit and a popcount helper.
// -----------------------------------------------------------------------------
package bert_pkg;

  // Pattern modes carried on ctrl_sig; codes 5..7 behave as MODE_HOLD.
  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_CONST = 3'd1,
    MODE_INC   = 3'd2,
    MODE_PRBS8 = 3'd3,
    MODE_ALT   = 3'd4
  } mode_e;

  localparam logic [7:0] PRBS_SEED     = 8'hFF;
  localparam logic [7:0] ALT_SEED      = 8'h55;
  localparam logic [7:0] ERR_SAT_LIMIT = 8'd255;

  // Number of set bits in an 8-bit error mask.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bert_pattern_gen.sv
// -----------------------------------------------------------------------------
// bert_pattern_gen
// Internal test-word generator. Holds a registered copy of the mode, an 8-bit
// incrementing counter, a PRBS-8 LFSR (x^8+x^6+x^5+x^4+1) and a 0x55/0xAA
// alternator. State advances only on i_tick; a mode change or i_reload
// restores all seeds on the next clock.
//
// Ports:
//   clock      in   system clock, rising edge
//   i_reload   in   synchronous reload of all generator state (used for reset)
//   i_tick     in   advance strobe from the rate divider
//   i_mode     in   [2:0] requested pattern mode
//   i_val      in   [2:0] source of the constant pattern
//   o_pattern  out  [7:0] current generator word
// -----------------------------------------------------------------------------
module bert_pattern_gen
  import bert_pkg::*;
(
  input  logic       clock,
  input  logic       i_reload,
  input  logic       i_tick,
  input  logic [2:0] i_mode,
  input  logic [2:0] i_val,
  output logic [7:0] o_pattern
);

  logic [2:0] r_mode;
  logic [7:0] r_cnt;
  logic [7:0] r_lfsr;
  logic [7:0] r_alt;

  logic       w_mode_change;
  logic       w_feedback;

  assign w_mode_change = (i_mode != r_mode);
  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
  assign w_feedback    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    // Mode copy tracks the input every clock; on reload it takes the current
    // input so a reset does not look like a mode change afterwards.
    r_mode <= i_mode;
    if (i_reload || w_mode_change) begin
      r_cnt  <= 8'd0;
      r_lfsr <= PRBS_SEED;
      r_alt  <= ALT_SEED;
    end else if (i_tick) begin
      r_cnt  <= r_cnt + 8'd1;
      r_lfsr <= {r_lfsr[6:0], w_feedback};
      r_alt  <= ~r_alt;
    end
  end

  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    o_pattern = 8'h00;
    case (r_mode)
      MODE_CONST: o_pattern = {i_val, i_val, i_val[1:0]};
      MODE_INC:   o_pattern = r_cnt;
      MODE_PRBS8: o_pattern = r_lfsr;
      MODE_ALT:   o_pattern = r_alt;
      default:    o_pattern = 8'h00;
    endcase
  end

endmodule

// File: rtl/combined_bert.sv
// -----------------------------------------------------------------------------
// combined_bert
// Single-clock bit-error-ratio tester. A rate divider produces a one-clock
// tick every wanted_cl_val clocks; on each tick the transmit word (internal
// generator or normal_input) passes through a deterministic error injector,
// is compared against itself, and the error mask, a saturating error-bit
// total and a compared-word count are updated.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   sel            in   1 = internal generator, 0 = normal_input
//   ctrl_sig       in   [2:0] pattern mode
//   val            in   [2:0] injection period control (0 = off), const pattern
//   wanted_cl_val  in   [24:0] clocks per word (0 treated as 1)
//   taps           in   signed [2:0] injected bit position, negative = off
//   normal_input   in   [7:0] external test word
//   error          out  [7:0] error mask of the latest compared word
//   total_error    out  [7:0] saturating errored-bit total
//   count          out  [31:0] compared-word count, wraps
// -----------------------------------------------------------------------------
module combined_bert
  import bert_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              sel,
  input  logic [2:0]        ctrl_sig,
  input  logic [2:0]        val,
  input  logic [24:0]       wanted_cl_val,
  input  logic signed [2:0] taps,
  input  logic [7:0]        normal_input,
  output logic [7:0]        error,
  output logic [7:0]        total_error,
  output logic [31:0]       count
);

  logic [24:0] r_div;
  logic [2:0]  r_idx;
  logic [7:0]  r_error;
  logic [7:0]  r_total;
  logic [31:0] r_count;

  logic [24:0] w_last;
  logic        w_tick;
  logic [7:0]  w_pattern;
  logic [7:0]  w_tx;
  logic        w_inject;
  logic [7:0]  w_mask;
  logic [7:0]  w_rx;
  logic [7:0]  w_err;
  logic [8:0]  w_sum;

  // ---------------------------------------------------------------- divider
  assign w_last = (wanted_cl_val == 25'd0) ? 25'd0 : wanted_cl_val - 25'd1;
  assign w_tick = (r_div == w_last);

  // A count already past a newly lowered terminal restarts without a tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div <= 25'd0;
    end else if (r_div >= w_last) begin
      r_div <= 25'd0;
    end else begin
      r_div <= r_div + 25'd1;
    end
  end

  // -------------------------------------------------------------- generator
  bert_pattern_gen u_pattern_gen (
    .clock     (clock),
    .i_reload  (reset),
    .i_tick    (w_tick),
    .i_mode    (ctrl_sig),
    .i_val     (val),
    .o_pattern (w_pattern)
  );

  assign w_tx = sel ? w_pattern : normal_input;

  // --------------------------------------------------------------- injector
  // Word index runs 0..val, so an injection lands on every (val+1)-th word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx <= 3'd0;
    end else if (w_tick) begin
      r_idx <= (r_idx >= val) ? 3'd0 : r_idx + 3'd1;
    end
  end

  assign w_inject = (val != 3'd0) && (r_idx == val) && !taps[2];
  assign w_mask   = w_inject ? (8'd1 << taps[1:0]) : 8'd0;
  assign w_rx     = w_tx ^ w_mask;

  // ---------------------------------------------------------------- checker
  assign w_err = w_rx ^ w_tx;
  assign w_sum = {1'b0, r_total} + {5'd0, popcount8(w_err)};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_error <= 8'd0;
      r_total <= 8'd0;
      r_count <= 32'd0;
    end else if (w_tick) begin
      r_error <= w_err;
      r_total <= (w_sum > {1'b0, ERR_SAT_LIMIT}) ? ERR_SAT_LIMIT : w_sum[7:0];
      r_count <= r_count + 32'd1;
    end
  end

  assign error       = r_error;
  assign total_error = r_total;
  assign count       = r_count;

endmodule

// File: tb/tb_combined_bert.sv
// -----------------------------------------------------------------------------
// tb_combined_bert
// Directed-vector bench for combined_bert with hand-computed expectations.
// The transmit word is observed through the top-level w_tx net.
// -----------------------------------------------------------------------------
module tb_combined_bert;

  logic              clock;
  logic              reset;
  logic              sel;
  logic [2:0]        ctrl_sig;
  logic [2:0]        val;
  logic [24:0]       wanted_cl_val;
  logic signed [2:0] taps;
  logic [7:0]        normal_input;
  logic [7:0]        error;
  logic [7:0]        total_error;
  logic [31:0]       count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] prbs_exp [6] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
  logic [7:0] ext_words [5] = '{8'd8, 8'd100, 8'd250, 8'd0, 8'hFB};

  combined_bert dut (
    .clock         (clock),
    .reset         (reset),
    .sel           (sel),
    .ctrl_sig      (ctrl_sig),
    .val           (val),
    .wanted_cl_val (wanted_cl_val),
    .taps          (taps),
    .normal_input  (normal_input),
    .error         (error),
    .total_error   (total_error),
    .count         (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic one_clock();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_total;

    // ---- reset state, reset overriding a tick every clock
    reset = 1'b1; sel = 1'b1; ctrl_sig = 3'd3; val = 3'd0; taps = 3'sd0;
    wanted_cl_val = 25'd1; normal_input = 8'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_error", {24'd0, error}, 32'd0);
    check("rst_total", {24'd0, total_error}, 32'd0);
    check("rst_count", count, 32'd0);
    reset = 1'b0;

    // ---- PRBS-8 at one word per clock, no injection
    for (int i = 0; i < 6; i++) begin
      check("prbs_tx", {24'd0, dut.w_tx}, {24'd0, prbs_exp[i]});
      one_clock();
      check("prbs_count", count, i + 1);
      check("prbs_error", {24'd0, error}, 32'd0);
    end
    check("prbs_total", {24'd0, total_error}, 32'd0);

    // ---- incrementing pattern, one word per 4 clocks, bit 3 every 8th word
    wanted_cl_val = 25'd4; ctrl_sig = 3'd2; val = 3'd7; taps = 3'sd3;
    do_reset();
    for (int w = 1; w <= 16; w++) begin
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("inc_tx", {24'd0, dut.w_tx}, w - 1);
      check("inc_hold", count, w - 1);
      one_clock();
      check("inc_count", count, w);
      check("inc_error", {24'd0, error}, (w % 8 == 0) ? 32'h08 : 32'h00);
      check("inc_total", {24'd0, total_error}, w / 8);
    end

    // ---- terminal lowered below the running count: restart, no tick
    wanted_cl_val = 25'd10;
    do_reset();
    repeat (6) @(posedge clock);
    @(negedge clock);
    wanted_cl_val = 25'd3;
    one_clock();
    check("lower_no_tick", count, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("lower_wait", count, 32'd0);
    one_clock();
    check("lower_tick", count, 32'd1);
    wanted_cl_val = 25'd0;
    one_clock();
    one_clock();
    check("zero_div_count", count, 32'd3);

    // ---- external words with negative taps: never an error
    sel = 1'b0; taps = -3'sd1; val = 3'd7; wanted_cl_val = 25'd1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      normal_input = ext_words[i];
      #1;
      check("ext_tx", {24'd0, dut.w_tx}, {24'd0, ext_words[i]});
      one_clock();
      check("ext_error", {24'd0, error}, 32'd0);
    end
    check("ext_count", count, 32'd5);
    check("ext_total", {24'd0, total_error}, 32'd0);

    // ---- saturation: bit 0 on every second word, total stops at 255
    sel = 1'b1; ctrl_sig = 3'd0; val = 3'd1; taps = 3'sd0; wanted_cl_val = 25'd1;
    do_reset();
    for (int k = 1; k <= 520; k++) begin
      one_clock();
      exp_total = (k / 2 > 255) ? 255 : k / 2;
      if (k <= 4)
        check("sat_error", {24'd0, error}, (k % 2 == 0) ? 32'h01 : 32'h00);
      if (k == 2 || k == 3 || k == 509 || k == 510 || k == 511 || k == 512 || k == 520)
        check("sat_total", {24'd0, total_error}, exp_total);
    end
    check("sat_count", count, 32'd520);

    // ---- mode change 1 -> 2 mid-run, then reset clears outputs
    sel = 1'b1; ctrl_sig = 3'd1; val = 3'd1; taps = 3'sd2; wanted_cl_val = 25'd1;
    do_reset();
    check("const_tx", {24'd0, dut.w_tx}, 32'h25);
    repeat (3) one_clock();
    check("pre_chg_count", count, 32'd3);
    check("pre_chg_total", {24'd0, total_error}, 32'd1);
    check("pre_chg_error", {24'd0, error}, 32'd0);
    ctrl_sig = 3'd2;
    #1;
    check("chg_old_tx", {24'd0, dut.w_tx}, 32'h25);
    one_clock();
    check("chg_restart_tx", {24'd0, dut.w_tx}, 32'h00);
    check("chg_count", count, 32'd4);
    check("chg_error", {24'd0, error}, 32'h04);
    check("chg_total", {24'd0, total_error}, 32'd2);
    one_clock();
    check("chg_next_tx", {24'd0, dut.w_tx}, 32'h01);
    check("chg_next_count", count, 32'd5);
    check("chg_next_total", {24'd0, total_error}, 32'd2);
    reset = 1'b1;
    one_clock();
    check("late_rst_error", {24'd0, error}, 32'd0);
    check("late_rst_total", {24'd0, total_error}, 32'd0);
    check("late_rst_count", count, 32'd0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/combined_bert.md
# combined_bert

Integrated single-clock bit-error-ratio tester. Generates an 8-bit test word stream, either from an internal pattern generator or the external `normal_input`, at a programmable rate. It passes the stream through a deterministic error-injection channel, compares against the transmitted word, and reports the per-word error mask, a saturating error-bit total and a compared-word count. It sits at the top of the BERT datapath, between the stimulus source and status/readout logic.

## Interface
- No parameters; widths are fixed.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  1  source select: 1 = internal pattern generator, 0 = `normal_input`.
- `ctrl_sig`  in  3  pattern mode (see Operation).
- `val`  in  3  error-injection period control; 0 disables injection.
- `wanted_cl_val`  in  25  rate divider terminal value; one word per `wanted_cl_val` clocks (0 treated as 1).
- `taps`  in  3 signed  injected bit position; 0..3 flips bit `taps`; negative values disable injection.
- `normal_input`  in  8  external test word, used when `sel`=0.
- `error`  out  8  error mask of the most recent compared word.
- `total_error`  out  8  accumulated errored bits, saturates at 255.
- `count`  out  32  number of compared words, wraps modulo 2^32.

## Operation
- Rate divider: 25-bit counter, 0 to `wanted_cl_val`-1. It asserts internal `tick` for one clock at the terminal value, then restarts at 0. If `wanted_cl_val` is lowered below the current count, the counter restarts at 0 on the next clock without a tick.
- Pattern modes, advancing only on `tick`:
  - 0: hold; output 0x00.
  - 1: constant; output {val, val, val[1:0]}. With `val`=7 this is 0xFF.
  - 2: incrementing 8-bit counter from 0x00, wrapping at 0xFF.
  - 3: PRBS-8 Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 0xFF, shifts left, feedback into bit 0.
  - 4: alternating 0x55 then 0xAA, starting with 0x55.
  - 5–7: as mode 0.
- A change of `ctrl_sig` is detected against a registered copy. It reloads the generator state (counter 0, LFSR 0xFF, alternator 0x55) on the next clock. `error`, `total_error` and `count` are not cleared.
- Transmit word `tx` = generator output if `sel`=1, else `normal_input`. It is sampled on `tick`.
- Injection: a 3-bit word index increments on each `tick` and wraps at `val`. Injection is active when `val`≠0, the index equals `val`, and 0 ≤ `taps` ≤ 3. The mask is then 1<<`taps`; otherwise the mask is 0. With `val`=7, `taps`=3, every 8th word gets mask 0x08.
- Received word `rx` = `tx` XOR mask. Compare: `error` = `rx` XOR `tx`.
- On each `tick`:
  - `count` += 1.
  - `total_error` = min(255, `total_error` + popcount(new `error`)).
- Between ticks, all outputs hold.

## Timing
- Reset, applied on any clock, takes effect on that clock and overrides `tick`. Afterwards:
  - `error`=0, `total_error`=0, `count`=0;
  - divider=0, injection index=0, generator reloaded.
- Latency: outputs update on the same clock edge where `tick` is high. The word sampled at tick k is reflected one clock later on the registered outputs.
- With `wanted_cl_val`≤1, `tick` is high every clock after reset.
- Mid-stream input changes (`sel`, `val`, `taps`, `normal_input`) take effect at the next `tick`. No handshake is used.

## Structure
- Shared package `bert_pkg`: mode constants (MODE_HOLD, MODE_CONST, MODE_INC, MODE_PRBS8, MODE_ALT), the PRBS seed 0xFF, and the saturation limit 255.
- One natural sub-module, `bert_pattern_gen`: holds the mode register, counter, LFSR and alternator, with inputs `tick`/reload. The divider, injector and checker stay in the top.

## Test plan
- Reset, then `wanted_cl_val`=1, `sel`=1, `ctrl_sig`=3, `val`=0: the PRBS sequence starts 0xFF, 0xFE, 0xFC… `error` stays 0x00, `count` increments every clock, `total_error`=0.
- `wanted_cl_val`=4, `ctrl_sig`=2, `val`=7, `taps`=3: `count` increments every 4 clocks. `error`=0x08 on every 8th word. `total_error`=2 after 16 words.
- `sel`=0, `normal_input` stepping 8, 100, 250, 0, 0xFB; `taps`=-1, `val`=7: `error`=0 throughout and `count`=5 after 5 ticks.
- Saturation: `wanted_cl_val`=1, `val`=1, `taps`=0. Every second word has `error`=0x01, and `total_error` must stop at 255, never wrapping to 0.
- `ctrl_sig` change 1→2 mid-run: the generator restarts at 0x00 and `count` is not reset. A later reset clears all outputs to 0 on the next edge.
